// File: rtl/vend_ctrl_param_if.sv
// -----------------------------------------------------------------------------
// vend_ctrl_param_if
//   Bundles the coin/selection inputs and the item/change/status outputs of
//   the parametrised vending controller.
//
//   Parameters:
//     ACC_W  credit width in half-farthings
//     SEL_W  item index width
//
//   Signals (direction as seen by the controller, i.e. the slave modport):
//     coin_valid, coin_type[1:0]      coin insertion strobe and code
//     sel_valid, sel[SEL_W-1:0]       item selection strobe and index
//     cancel                          refund request strobe
//     credit[ACC_W-1:0]               current credit
//     busy                            vend or change payout in progress
//     item_vend, item_id[SEL_W-1:0]   dispense pulse and item index
//     change_valid, change_coin[1:0]  one change coin per cycle
//     coin_reject                     inserted coin is returned
//     insufficient                    selection refused for lack of credit
//     sold_out                        selection refused, item out of stock
//                                     (present only with STOCK_COUNT_EN)
//
//   master: the stimulus side (debounced inputs, LED / 7-segment drivers)
//   slave : the controller
// -----------------------------------------------------------------------------
interface vend_ctrl_param_if #(
  parameter int ACC_W = 6,
  parameter int SEL_W = 1
);
  logic             coin_valid;
  logic [1:0]       coin_type;
  logic             sel_valid;
  logic [SEL_W-1:0] sel;
  logic             cancel;
  logic [ACC_W-1:0] credit;
  logic             busy;
  logic             item_vend;
  logic [SEL_W-1:0] item_id;
  logic             change_valid;
  logic [1:0]       change_coin;
  logic             coin_reject;
  logic             insufficient;
`ifdef STOCK_COUNT_EN
  logic             sold_out;

  modport master (
    output coin_valid, coin_type, sel_valid, sel, cancel,
    input  credit, busy, item_vend, item_id, change_valid, change_coin,
           coin_reject, insufficient, sold_out
  );
  modport slave (
    input  coin_valid, coin_type, sel_valid, sel, cancel,
    output credit, busy, item_vend, item_id, change_valid, change_coin,
           coin_reject, insufficient, sold_out
  );
`else
  modport master (
    output coin_valid, coin_type, sel_valid, sel, cancel,
    input  credit, busy, item_vend, item_id, change_valid, change_coin,
           coin_reject, insufficient
  );
  modport slave (
    input  coin_valid, coin_type, sel_valid, sel, cancel,
    output credit, busy, item_vend, item_id, change_valid, change_coin,
           coin_reject, insufficient
  );
`endif
endinterface

// File: rtl/vend_ctrl_param.sv
// -----------------------------------------------------------------------------
// vend_ctrl_param
//   Multi-item coin vending controller. Credit is kept in half-farthings;
//   coins are half-farthing (1), farthing (2) and penny (8). Item i costs
//   PRICE_BASE + i*PRICE_STEP. After a vend or a cancel the remaining credit
//   is paid back one coin per cycle, largest coin first.
//
//   Ports:
//     CLK  system clock, rising edge
//     RES  synchronous active-low reset
//     bus  vend_ctrl_param_if.slave (coin/selection in, item/change out)
//
//   Optional feature (macro STOCK_COUNT_EN):
//     per-item stock counters loaded with STOCK_INIT at reset; selecting an
//     empty item pulses sold_out instead of vending. Without the macro stock
//     is unlimited and the sold_out signal does not exist.
// -----------------------------------------------------------------------------
module vend_ctrl_param #(
  parameter int ACC_W      = 6,
  parameter int N_ITEMS    = 2,
  parameter int PRICE_BASE = 8,
  parameter int PRICE_STEP = 4,
  parameter int STOCK_INIT = 3
) (
  input logic              CLK,
  input logic              RES,
  vend_ctrl_param_if.slave bus
);

  localparam int SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  // Coin sums are formed 4 bits wider than the accumulator so an
  // overflowing insertion is detected instead of wrapping.
  localparam int SUM_W = ACC_W + 4;
  localparam logic [SUM_W-1:0] MAX_CREDIT = SUM_W'((1 << ACC_W) - 1);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  function automatic logic [SUM_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   return SUM_W'(1);
      2'b10:   return SUM_W'(2);
      2'b11:   return SUM_W'(8);
      default: return '0;
    endcase
  endfunction

  function automatic logic [1:0] greedy_coin(input logic [ACC_W-1:0] c);
    if ({4'b0000, c} >= SUM_W'(8))      return 2'b11;
    else if ({4'b0000, c} >= SUM_W'(2)) return 2'b10;
    else                                return 2'b01;
  endfunction

  state_t           state, state_n;
  logic [ACC_W-1:0] credit, credit_n;
  logic [SEL_W-1:0] item_id, item_id_n;
  logic             busy, busy_n;
  logic             item_vend, item_vend_n;
  logic             change_valid, change_valid_n;
  logic [1:0]       change_coin, change_coin_n;
  logic             coin_reject, coin_reject_n;
  logic             insufficient, insufficient_n;

  logic             coin_in, take_coin, pay_out, sel_ok, afford;
  logic [SUM_W-1:0] coin_sum, refund_w;
  int               price;

`ifdef STOCK_COUNT_EN
  localparam int STK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;
  logic [STK_W-1:0] stock [N_ITEMS];
  logic             sold_out, sold_out_n;
`endif

  // NOTE: every variable gets its default first, so no path through the
  // decision tree leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n        = state;
    credit_n       = credit;
    item_id_n      = item_id;
    item_vend_n    = 1'b0;
    change_valid_n = 1'b0;
    change_coin_n  = 2'b00;
    coin_reject_n  = 1'b0;
    insufficient_n = 1'b0;
`ifdef STOCK_COUNT_EN
    sold_out_n     = 1'b0;
`endif
    take_coin = 1'b0;
    pay_out   = 1'b0;
    refund_w  = '0;
    coin_in   = bus.coin_valid && (bus.coin_type != 2'b00);
    coin_sum  = {4'b0000, credit} + coin_value(bus.coin_type);
    price     = PRICE_BASE + int'(bus.sel) * PRICE_STEP;
    sel_ok    = int'(bus.sel) < N_ITEMS;
    afford    = int'(credit) >= price;

    case (state)
      IDLE: begin
        // Priority: cancel, then selection, then coin.
        if (bus.cancel) begin
          coin_reject_n = coin_in;
          pay_out       = (credit != '0);
        end else if (bus.sel_valid) begin
          if (!sel_ok) begin
            insufficient_n = 1'b1;
            take_coin      = 1'b1;
          end
`ifdef STOCK_COUNT_EN
          else if (stock[bus.sel] == '0) begin
            sold_out_n = 1'b1;
            take_coin  = 1'b1;
          end
`endif
          else if (afford) begin
            credit_n      = credit - ACC_W'(price);
            item_id_n     = bus.sel;
            item_vend_n   = 1'b1;
            state_n       = VEND;
            coin_reject_n = coin_in;
          end else begin
            insufficient_n = 1'b1;
            take_coin      = 1'b1;
          end
        end else begin
          take_coin = 1'b1;
        end

        if (take_coin && coin_in) begin
          if (coin_sum <= MAX_CREDIT) credit_n = coin_sum[ACC_W-1:0];
          else                        coin_reject_n = 1'b1;
        end
      end

      VEND, CHANGE: begin
        coin_reject_n = coin_in;
        if (credit != '0) pay_out = 1'b1;
        else              state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // The coin paid out is presented in the same cycle its value leaves the
    // credit, so the first coin follows the vend cycle with no bubble.
    if (pay_out) begin
      change_valid_n = 1'b1;
      change_coin_n  = greedy_coin(credit);
      refund_w       = coin_value(change_coin_n);
      credit_n       = credit - refund_w[ACC_W-1:0];
      state_n        = CHANGE;
    end

    busy_n = (state_n != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RES) begin
      state        <= IDLE;
      credit       <= '0;
      item_id      <= '0;
      busy         <= 1'b0;
      item_vend    <= 1'b0;
      change_valid <= 1'b0;
      change_coin  <= 2'b00;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
`ifdef STOCK_COUNT_EN
      sold_out     <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      credit       <= credit_n;
      item_id      <= item_id_n;
      busy         <= busy_n;
      item_vend    <= item_vend_n;
      change_valid <= change_valid_n;
      change_coin  <= change_coin_n;
      coin_reject  <= coin_reject_n;
      insufficient <= insufficient_n;
`ifdef STOCK_COUNT_EN
      sold_out     <= sold_out_n;
`endif
    end
  end

`ifdef STOCK_COUNT_EN
  // NOTE: the stock array is a handful of small counters with a defined
  // reset value, so it is built from resettable flops rather than a RAM.
  always_ff @(posedge CLK) begin
    if (!RES) begin
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= STK_W'(STOCK_INIT);
    end else if (state == VEND) begin
      // An empty item is never accepted, so this cannot wrap.
      stock[item_id] <= stock[item_id] - STK_W'(1);
    end
  end

  assign bus.sold_out = sold_out;
`endif

  assign bus.credit       = credit;
  assign bus.busy         = busy;
  assign bus.item_vend    = item_vend;
  assign bus.item_id      = item_id;
  assign bus.change_valid = change_valid;
  assign bus.change_coin  = change_coin;
  assign bus.coin_reject  = coin_reject;
  assign bus.insufficient = insufficient;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_vend_ctrl_param
//   Directed bench for vend_ctrl_param. Stimulus pushes the expected pulse
//   events (with the credit expected alongside them) into per-output queues;
//   a negedge monitor pops and compares whenever the DUT raises an output.
//   Credit and busy are also checked directly at fixed points.
// -----------------------------------------------------------------------------
module tb_vend_ctrl_param;

  localparam int ACC_W   = 6;
  localparam int N_ITEMS = 2;
  localparam int SEL_W   = 1;
`ifdef STOCK_COUNT_EN
  localparam int STOCK_INIT = 1;
`else
  localparam int STOCK_INIT = 3;
`endif

  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] FART = 2'b10;
  localparam logic [1:0] PENNY = 2'b11;

  logic CLK = 1'b0;
  logic RES = 1'b0;

  always #5 CLK = ~CLK;

  vend_ctrl_param_if #(.ACC_W(ACC_W), .SEL_W(SEL_W)) bus ();

  vend_ctrl_param #(
    .ACC_W      (ACC_W),
    .N_ITEMS    (N_ITEMS),
    .PRICE_BASE (8),
    .PRICE_STEP (4),
    .STOCK_INIT (STOCK_INIT)
  ) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus)
  );

  typedef struct {
    int a;       // item id or coin code (unused for plain pulses)
    int credit;  // credit expected while the output is high
  } exp_t;

  exp_t q_vend[$];
  exp_t q_change[$];
  exp_t q_reject[$];
  exp_t q_insuff[$];
  exp_t q_sold[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int credit_now);
    n_checks++;
    n_fail++;
    $display("FAIL %s: pulse seen with credit %0d, none expected", name, credit_now);
  endtask

  // Monitor: outputs settle after the rising edge, sample on the falling one.
  always @(negedge CLK) begin
    exp_t e;
    if (bus.item_vend === 1'b1) begin
      if (q_vend.size() == 0) unexpected("item_vend", int'(bus.credit));
      else begin
        e = q_vend.pop_front();
        check("vend_item_id", int'(bus.item_id), e.a);
        check("vend_credit", int'(bus.credit), e.credit);
      end
    end
    if (bus.change_valid === 1'b1) begin
      if (q_change.size() == 0) unexpected("change_valid", int'(bus.credit));
      else begin
        e = q_change.pop_front();
        check("change_coin", int'(bus.change_coin), e.a);
        check("change_credit", int'(bus.credit), e.credit);
      end
    end
    if (bus.coin_reject === 1'b1) begin
      if (q_reject.size() == 0) unexpected("coin_reject", int'(bus.credit));
      else begin
        e = q_reject.pop_front();
        check("reject_credit", int'(bus.credit), e.credit);
      end
    end
    if (bus.insufficient === 1'b1) begin
      if (q_insuff.size() == 0) unexpected("insufficient", int'(bus.credit));
      else begin
        e = q_insuff.pop_front();
        check("insuff_credit", int'(bus.credit), e.credit);
      end
    end
`ifdef STOCK_COUNT_EN
    if (bus.sold_out === 1'b1) begin
      if (q_sold.size() == 0) unexpected("sold_out", int'(bus.credit));
      else begin
        e = q_sold.pop_front();
        check("sold_credit", int'(bus.credit), e.credit);
      end
    end
`endif
  end

  function automatic exp_t mk(input int a, input int credit);
    exp_t e;
    e.a = a;
    e.credit = credit;
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] t);
    bus.coin_valid = 1'b1;
    bus.coin_type  = t;
    tick();
    bus.coin_valid = 1'b0;
    bus.coin_type  = 2'b00;
  endtask

  task automatic select(input int s);
    bus.sel_valid = 1'b1;
    bus.sel       = SEL_W'(s);
    tick();
    bus.sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
  endtask

  initial begin
    bus.coin_valid = 1'b0;
    bus.coin_type  = 2'b00;
    bus.sel_valid  = 1'b0;
    bus.sel        = '0;
    bus.cancel     = 1'b0;

    // Reset with a coin being offered: reset must win.
    RES = 1'b0;
    bus.coin_valid = 1'b1;
    bus.coin_type  = PENNY;
    tick();
    tick();
    bus.coin_valid = 1'b0;
    bus.coin_type  = 2'b00;
    RES = 1'b1;
    check("rst_credit", int'(bus.credit), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_item_vend", int'(bus.item_vend), 0);
    check("rst_item_id", int'(bus.item_id), 0);
    check("rst_change_valid", int'(bus.change_valid), 0);
    check("rst_change_coin", int'(bus.change_coin), 0);
    check("rst_coin_reject", int'(bus.coin_reject), 0);
    check("rst_insufficient", int'(bus.insufficient), 0);

    // Two pennies, buy item 1 (price 12): change 4 = farthing + farthing.
    put_coin(PENNY);
    put_coin(PENNY);
    check("a_credit16", int'(bus.credit), 16);
    q_vend.push_back(mk(1, 4));
    q_change.push_back(mk(2, 2));
    q_change.push_back(mk(2, 0));
    select(1);
    check("a_busy_vend", int'(bus.busy), 1);
    repeat (4) tick();
    check("a_credit_end", int'(bus.credit), 0);
    check("a_busy_end", int'(bus.busy), 0);

    // Three half-farthings, cancel with a coin in the same cycle.
    repeat (3) put_coin(HALF);
    check("b_credit3", int'(bus.credit), 3);
    q_reject.push_back(mk(0, 1));
    q_change.push_back(mk(2, 1));
    q_change.push_back(mk(1, 0));
    bus.cancel     = 1'b1;
    bus.coin_valid = 1'b1;
    bus.coin_type  = HALF;
    tick();
    bus.cancel     = 1'b0;
    bus.coin_valid = 1'b0;
    bus.coin_type  = 2'b00;
    repeat (4) tick();
    check("b_credit_end", int'(bus.credit), 0);
    check("b_busy_end", int'(bus.busy), 0);

    // Credit 6 is short for item 0 (price 8); a farthing makes it exact.
    repeat (3) put_coin(FART);
    check("c_credit6", int'(bus.credit), 6);
    q_insuff.push_back(mk(0, 6));
    select(0);
    check("c_credit_after_insuff", int'(bus.credit), 6);
    check("c_busy_after_insuff", int'(bus.busy), 0);
    put_coin(FART);
    check("c_credit8", int'(bus.credit), 8);
    q_vend.push_back(mk(0, 0));
    select(0);
    repeat (3) tick();
    check("c_credit_end", int'(bus.credit), 0);
    check("c_busy_end", int'(bus.busy), 0);

    // Overflow boundary at 63, coin during CHANGE, reset mid-CHANGE.
    repeat (7) put_coin(PENNY);
    repeat (2) put_coin(FART);
    check("d_credit60", int'(bus.credit), 60);
    q_reject.push_back(mk(0, 60));
    put_coin(PENNY);
    check("d_credit60_kept", int'(bus.credit), 60);
    put_coin(HALF);
    put_coin(FART);
    check("d_credit63", int'(bus.credit), 63);
    q_reject.push_back(mk(0, 63));
    put_coin(HALF);
    check("d_credit63_kept", int'(bus.credit), 63);
    q_change.push_back(mk(3, 55));
    do_cancel();
    check("d_busy_change", int'(bus.busy), 1);
    check("d_credit55", int'(bus.credit), 55);
    q_change.push_back(mk(3, 47));
    q_reject.push_back(mk(0, 47));
    put_coin(PENNY);
    check("d_credit47", int'(bus.credit), 47);
    RES = 1'b0;
    tick();
    RES = 1'b1;
    check("d_rst_credit", int'(bus.credit), 0);
    check("d_rst_change_valid", int'(bus.change_valid), 0);
    check("d_rst_busy", int'(bus.busy), 0);
    check("d_rst_coin_reject", int'(bus.coin_reject), 0);
    tick();
    check("d_idle_after_rst", int'(bus.change_valid), 0);

`ifdef STOCK_COUNT_EN
    // Single unit of item 0: the second purchase is refused.
    put_coin(PENNY);
    q_vend.push_back(mk(0, 0));
    select(0);
    repeat (3) tick();
    put_coin(PENNY);
    check("e_credit8", int'(bus.credit), 8);
    q_sold.push_back(mk(0, 8));
    select(0);
    check("e_credit8_kept", int'(bus.credit), 8);
    check("e_busy", int'(bus.busy), 0);
    q_change.push_back(mk(3, 0));
    do_cancel();
    repeat (3) tick();
    check("e_credit_end", int'(bus.credit), 0);
`endif

    repeat (3) tick();
    check("pending_vend", q_vend.size(), 0);
    check("pending_change", q_change.size(), 0);
    check("pending_reject", q_reject.size(), 0);
    check("pending_insuff", q_insuff.size(), 0);
    check("pending_sold", q_sold.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_param.md
Name: vend_ctrl_param

Overview:
- Parametrised successor to the single-item coin vending FSM.
- Accepts half-farthing, farthing and penny coins into a credit accumulator counted in half-farthings.
- Serves N_ITEMS selectable items, each with its own price.
- Returns change one coin per cycle using a greedy sequencer; supports cancel/refund.
- Sits between the debounced coin/selection inputs and the item/change LED and 7-segment drivers.

Parameters:
- ACC_W, 6, credit accumulator width in half-farthings (max credit 2^ACC_W-1).
- N_ITEMS, 2, number of selectable items.
- PRICE_BASE, 8, price of item 0 in half-farthings (8 = 1 penny).
- PRICE_STEP, 4, price increment per item index: price(i) = PRICE_BASE + i*PRICE_STEP.
- STOCK_INIT, 3, per-item stock loaded at reset; used only with STOCK_COUNT_EN.

Ports:
- CLK  in  1  system clock, rising edge.
- RES  in  1  reset, synchronous, active-low.
- coin_valid  in  1  one-cycle coin insertion strobe.
- coin_type  in  2  01 half-farthing (1), 10 farthing (2), 11 penny (8); 00 is ignored.
- sel_valid  in  1  one-cycle item selection strobe.
- sel  in  SEL_W  item index; SEL_W = max(1, clog2(N_ITEMS)).
- cancel  in  1  one-cycle refund request.
- credit  out  ACC_W  current credit in half-farthings.
- busy  out  1  high in VEND or CHANGE.
- item_vend  out  1  one-cycle dispense pulse.
- item_id  out  SEL_W  index of the vended item; valid with item_vend.
- change_valid  out  1  a change coin is presented this cycle.
- change_coin  out  2  coin code as for coin_type; valid with change_valid.
- coin_reject  out  1  one-cycle pulse; the inserted coin is returned.
- insufficient  out  1  one-cycle pulse; selection refused for lack of credit.
- sold_out  out  1  only with STOCK_COUNT_EN; one-cycle pulse.

Behaviour:
- Reset and registering:
  - All outputs are registered.
  - When RES=0 at a rising CLK edge: state=IDLE, credit=0, all pulses and valids=0, item_id=0, change_coin=00.
  - Reset overrides everything, including mid-VEND or mid-CHANGE; no change is paid out for the credit cleared.
- States: IDLE, VEND, CHANGE.
- IDLE priority per cycle is cancel > sel_valid > coin_valid.
  - cancel:
    - With credit>0, go to CHANGE.
    - With credit=0, stay in IDLE with no effect.
    - A coin in the same cycle is rejected.
  - sel_valid with sel<N_ITEMS and credit>=price(sel):
    - credit <= credit-price.
    - Go to VEND.
    - A coin in the same cycle is rejected.
  - sel_valid with credit<price or sel>=N_ITEMS:
    - insufficient pulses next cycle.
    - A coin in the same cycle is still evaluated.
  - coin_valid with a nonzero code:
    - If credit+value <= 2^ACC_W-1, credit updates at that edge.
    - Otherwise credit is unchanged and coin_reject pulses.
    - Width rule: compare at ACC_W+4 bits; never wrap.
- VEND (exactly 1 cycle):
  - item_vend=1 and item_id=sel latched at acceptance.
  - Next state is CHANGE if credit>0, else IDLE.
- CHANGE:
  - Each cycle: change_valid=1 with the coin chosen greedily, then credit decremented by its value.
    - credit>=8 gives penny.
    - credit>=2 gives farthing.
    - Otherwise half-farthing.
  - Return to IDLE in the cycle after credit reaches 0.
- Latency:
  - Coin accepted at edge N: credit visible after edge N.
  - Selection accepted at edge N: item_vend high during cycle N+1; first change coin in cycle N+2.
- In VEND and CHANGE:
  - Any coin_valid is answered with coin_reject.
  - sel_valid and cancel are ignored.
- Refund and payout: change total always equals credit at VEND exit or cancel; no over- or under-pay.

Optional Feature:
- Macro: STOCK_COUNT_EN.
- Defined:
  - Per-item stock counters of width clog2(STOCK_INIT+1), loaded with STOCK_INIT on reset.
  - Each counter is decremented on that item's VEND.
  - A selection of an item with stock 0 is refused: sold_out pulses, credit is unchanged, and insufficient is not asserted.
- Undefined:
  - No counters; stock is unlimited.
  - sold_out port absent.

Test Plan:
- RES=0 for 1 edge after random activity -> credit=0, busy=0, all pulse/valid outputs 0 next cycle.
- Penny, penny (credit 16), sel=1 (price 12) -> item_vend=1, item_id=1, credit=4; then two cycles of change_valid with change_coin=10; then IDLE, credit=0.
- 3 half-farthings (credit 3), cancel -> change farthing then half-farthing, no item_vend, credit=0.
- Credit 6, sel=0 (price 8) -> insufficient pulse, credit stays 6; then a farthing brings credit to 8, sel=0 -> vend, no change.
- Credit 60, penny -> coin_reject, credit stays 60; coin during CHANGE -> coin_reject; RES=0 mid-CHANGE -> credit=0, change_valid=0 next cycle.
- With STOCK_COUNT_EN and STOCK_INIT=1: item 0 vended once, then credit 8 with sel=0 -> sold_out pulse, credit stays 8.
